// File: rtl/axil_mem_pkg.sv
// Shared types and helpers for the AXI4-Lite to memory bridge.
//   resp_t     : AXI response codes used by the bridge (OKAY / SLVERR)
//   rd_tag_t   : per-read tag carried alongside the memory read latency
//   word_index : byte address -> memory word index (before truncation)
package axil_mem_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef struct packed {
    logic valid;
    logic err;
  } rd_tag_t;

  // Computed at 64 bits so an address below the base wraps to a huge index,
  // which the range check then sees as out of range.
  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input logic [63:0] base,
                                             input int unsigned off_w);
    return (addr - base) >> off_w;
  endfunction

endpackage

// File: rtl/axil_mem_rfifo.sv
// Synchronous FIFO holding read responses {rdata, rresp}.
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write side (ignored when full)
//   pop, dout  : read side; dout is the head entry (ignored when empty)
//   full, empty, count : occupancy
module axil_mem_rfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage is not reset; the head is only observed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

endmodule

// File: rtl/axi4_lite_mem_bridge.sv
// AXI4-Lite slave bridging to a simple dual-port synchronous memory.
// Write side: one-entry AW and W buffers filled independently, one memory
// write per cycle with byte enables. Read side: pipelined reads with up to
// RFIFO_DEPTH outstanding, in-order responses through a FIFO.
// Optional macro AXIL_MEM_RANGE_CHECK_EN: out-of-window accesses get SLVERR
// and no memory access; without it the word index wraps modulo 2^MEM_AW.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*             : AXI4-Lite write channels
//   s_ar*/s_r*                  : AXI4-Lite read channels
//   mem_wen/waddr/wdata/wbe     : memory write port
//   mem_ren/raddr, mem_rdata    : memory read port, data RD_LAT cycles later
module axi4_lite_mem_bridge
  import axil_mem_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                MEM_AW      = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                RD_LAT      = 1,
  parameter int                RFIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [1:0]          s_bresp,
  input  logic                s_arvalid,
  output logic                s_arready,
  input  logic [ADDR_W-1:0]   s_araddr,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                mem_wen,
  output logic [MEM_AW-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wbe,
  output logic                mem_ren,
  output logic [MEM_AW-1:0]   mem_raddr,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(RFIFO_DEPTH) + 1;
  localparam int FIFO_W = DATA_W + 2;

  // ---------------------------------------------------------------- decode
  logic [63:0] aw_idx_full, ar_idx_full;
  logic        aw_oor, ar_oor;

  assign aw_idx_full = word_index(64'(s_awaddr), 64'(BASE_ADDR), OFF_W);
  assign ar_idx_full = word_index(64'(s_araddr), 64'(BASE_ADDR), OFF_W);

`ifdef AXIL_MEM_RANGE_CHECK_EN
  // Any index bit at or above MEM_AW means outside the window (including
  // addresses below the base, which wrap to a huge index).
  assign aw_oor = |(aw_idx_full >> MEM_AW);
  assign ar_oor = |(ar_idx_full >> MEM_AW);
`else
  logic unused_idx_hi;
  assign unused_idx_hi = ^{aw_idx_full[63:MEM_AW], ar_idx_full[63:MEM_AW]};
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  // ------------------------------------------------------------ write path
  logic              aw_full, w_full, aw_err;
  logic [MEM_AW-1:0] aw_idx;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              aw_hs, w_hs, wr_issue;
  resp_t             bresp;

  assign wr_issue  = aw_full & w_full & (~s_bvalid | s_bready);
  assign s_awready = ~aw_full | wr_issue;
  assign s_wready  = ~w_full | wr_issue;
  assign aw_hs     = s_awvalid & s_awready;
  assign w_hs      = s_wvalid & s_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full  <= 1'b0;
      aw_idx   <= '0;
      aw_err   <= 1'b0;
      w_full   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      s_bvalid <= 1'b0;
      bresp    <= OKAY;
    end else begin
      // A new beat may land in the same cycle the old one issues.
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= aw_idx_full[MEM_AW-1:0];
        aw_err  <= aw_oor;
      end else if (wr_issue) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= s_wdata;
        w_strb <= s_wstrb;
      end else if (wr_issue) begin
        w_full <= 1'b0;
      end
      // wr_issue implies the previous B is gone or leaving this cycle.
      if (wr_issue) begin
        s_bvalid <= 1'b1;
        bresp    <= aw_err ? SLVERR : OKAY;
      end else if (s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  assign s_bresp   = bresp;
  assign mem_wen   = wr_issue & ~aw_err;
  assign mem_waddr = mem_wen ? aw_idx : '0;
  assign mem_wdata = mem_wen ? w_data : '0;
  assign mem_wbe   = mem_wen ? w_strb : '0;

  // ------------------------------------------------------------- read path
  logic                       ar_hs, pop;
  logic [CNT_W-1:0]           credit;
  rd_tag_t [RD_LAT-1:0]       tag_pipe;
  rd_tag_t                    tag_out;
  logic [FIFO_W-1:0]          push_data, fifo_dout;
  logic                       fifo_full, fifo_empty;
  logic [$clog2(RFIFO_DEPTH):0] fifo_count;

  // credit covers both reads in the memory pipe and entries in the FIFO,
  // so every accepted read is guaranteed a FIFO slot on return.
  assign s_arready = (credit < CNT_W'(RFIFO_DEPTH));
  assign ar_hs     = s_arvalid & s_arready;
  assign mem_ren   = ar_hs & ~ar_oor;
  assign mem_raddr = mem_ren ? ar_idx_full[MEM_AW-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_pipe <= '0;
      credit   <= '0;
    end else begin
      tag_pipe[0].valid <= ar_hs;
      tag_pipe[0].err   <= ar_hs & ar_oor;
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      credit <= credit + CNT_W'(ar_hs) - CNT_W'(pop);
    end
  end

  assign tag_out   = tag_pipe[RD_LAT-1];
  assign push_data = tag_out.err ? {{DATA_W{1'b0}}, SLVERR} : {mem_rdata, OKAY};

  axil_mem_rfifo #(
    .DEPTH (RFIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_rfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_out.valid),
    .din   (push_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  logic unused_fifo;
  assign unused_fifo = ^{fifo_full, fifo_count};

  assign s_rvalid = ~fifo_empty;
  assign pop      = s_rvalid & s_rready;
  assign s_rdata  = s_rvalid ? fifo_dout[FIFO_W-1:2] : '0;
  assign s_rresp  = s_rvalid ? fifo_dout[1:0] : 2'b00;

endmodule
